// File: rtl/rtype_exec_seq.sv
// rtype_exec_seq: multi-cycle MIPS R-type execution sequencer (ALU initiator).
//
// Accepts one R-type instruction per valid/ready handshake. It then reads the
// operands from an internal 32x32 register file and drives the external ALU's
// select bits and operands. It captures the ALU result and flags, and writes
// the result back to rd.
// Sequence: IDLE -> READ -> EXEC -> WB -> IDLE. A handshake in cycle N gives
// a done pulse in cycle N+3.
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   instr_valid/instr_ready      instruction handshake (ready only in IDLE)
//   instr[31:0]                  R-type word op|rs|rt|rd|shamt|funct
//   ALUselector2..0, alu_a/alu_b registered ALU select bits and operands
//   alu_res/alu_zero/alu_overflow ALU response, sampled at end of EXEC
//   done                         one-cycle completion pulse (WB)
//   result/result_zero/ovf_trap/illegal  completion data, valid with done
//   dbg_addr/dbg_data            combinational register read side channel
//
// Parameter TRAP_ON_OVF: 1 = signed add/sub overflow suppresses writeback and
// raises ovf_trap; 0 = always write back.
module rtype_exec_seq #(
  parameter bit TRAP_ON_OVF = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic        ALUselector2,
  output logic        ALUselector1,
  output logic        ALUselector0,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_res,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  output logic        done,
  output logic [31:0] result,
  output logic        result_zero,
  output logic        ovf_trap,
  output logic        illegal,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] regs [32];
  logic [31:0] instr_q;
  logic [2:0]  alu_sel;
  logic        is_add_q;
  logic        is_sub_q;
  logic        ill_q;
  logic        wen_q;

  logic [2:0]  dec_sel;
  logic        dec_shift;
  logic        dec_add;
  logic        dec_sub;
  logic        dec_legal;
  logic        sub_ovf;
  logic        trap;

  // Register 0 is hard-wired to zero regardless of the array contents.
  function automatic logic [31:0] read_reg(input logic [4:0] a, input logic [31:0] v);
    return (a == 5'd0) ? 32'd0 : v;
  endfunction

  assign ALUselector2 = alu_sel[2];
  assign ALUselector1 = alu_sel[1];
  assign ALUselector0 = alu_sel[0];
  assign dbg_data     = read_reg(dbg_addr, regs[dbg_addr]);

  // Decode the latched instruction word into ALU select and operand routing.
  always_comb begin
    dec_sel   = 3'b000;
    dec_shift = 1'b0;
    dec_add   = 1'b0;
    dec_sub   = 1'b0;
    dec_legal = 1'b0;
    if (instr_q[31:26] == 6'd0) begin
      dec_legal = 1'b1;
      case (instr_q[5:0])
        6'h24:   dec_sel = 3'b000;
        6'h25:   dec_sel = 3'b001;
        6'h20: begin
          dec_sel = 3'b010;
          dec_add = 1'b1;
        end
        6'h21:   dec_sel = 3'b010;
        6'h26:   dec_sel = 3'b011;
        6'h22: begin
          dec_sel = 3'b100;
          dec_sub = 1'b1;
        end
        6'h23:   dec_sel = 3'b100;
        6'h02: begin
          dec_sel   = 3'b101;
          dec_shift = 1'b1;
        end
        6'h00: begin
          dec_sel   = 3'b110;
          dec_shift = 1'b1;
        end
        6'h27:   dec_sel = 3'b111;
        default: dec_legal = 1'b0;
      endcase
    end else begin
      dec_legal = 1'b0;
    end
  end

  // Overflow resolution in EXEC. The ALU flag is add-form only, so subtract
  // overflow is derived here from the operand and result sign bits.
  always_comb begin
    sub_ovf = (alu_a[31] != alu_b[31]) && (alu_res[31] != alu_a[31]);
    trap    = TRAP_ON_OVF && ((is_add_q && alu_overflow) || (is_sub_q && sub_ovf));
  end

  // Sequencer FSM with registered outputs and the register file write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      instr_ready <= 1'b1;
      instr_q     <= 32'd0;
      alu_sel     <= 3'b000;
      alu_a       <= 32'd0;
      alu_b       <= 32'd0;
      is_add_q    <= 1'b0;
      is_sub_q    <= 1'b0;
      ill_q       <= 1'b0;
      wen_q       <= 1'b0;
      done        <= 1'b0;
      result      <= 32'd0;
      result_zero <= 1'b0;
      ovf_trap    <= 1'b0;
      illegal     <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'd0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (instr_valid) begin
            instr_q     <= instr;
            instr_ready <= 1'b0;
            state       <= READ;
          end
        end
        READ: begin
          // Illegal words drive zero selects/operands to the ALU.
          if (dec_legal) begin
            alu_sel <= dec_sel;
            alu_a   <= dec_shift ? read_reg(instr_q[20:16], regs[instr_q[20:16]])
                                 : read_reg(instr_q[25:21], regs[instr_q[25:21]]);
            alu_b   <= dec_shift ? {27'd0, instr_q[10:6]}
                                 : read_reg(instr_q[20:16], regs[instr_q[20:16]]);
          end else begin
            alu_sel <= 3'b000;
            alu_a   <= 32'd0;
            alu_b   <= 32'd0;
          end
          is_add_q <= dec_add && dec_legal;
          is_sub_q <= dec_sub && dec_legal;
          ill_q    <= !dec_legal;
          state    <= EXEC;
        end
        EXEC: begin
          result      <= alu_res;
          result_zero <= alu_zero;
          ovf_trap    <= trap;
          illegal     <= ill_q;
          done        <= 1'b1;
          wen_q       <= !ill_q && !trap && (instr_q[15:11] != 5'd0);
          state       <= WB;
        end
        WB: begin
          done        <= 1'b0;
          if (wen_q) begin
            regs[instr_q[15:11]] <= result;
          end
          instr_ready <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          done        <= 1'b0;
          instr_ready <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rtype_exec_seq.sv
// Self-checking bench for rtype_exec_seq: directed sequence plus randomized
// instructions, checked every cycle against a behavioural model.
module tb_rtype_exec_seq;

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        sel2, sel1, sel0;
  logic [31:0] alu_a, alu_b, alu_res;
  logic        alu_zero, alu_overflow;
  logic        done;
  logic [31:0] result;
  logic        result_zero, ovf_trap, illegal;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int total = 0;
  int bad   = 0;

  rtype_exec_seq #(.TRAP_ON_OVF(1'b1)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .ALUselector2(sel2), .ALUselector1(sel1), .ALUselector0(sel0),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_res(alu_res), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .done(done), .result(result), .result_zero(result_zero),
    .ovf_trap(ovf_trap), .illegal(illegal),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU: combinational, overflow flag is add-form for every select.
  logic [31:0] alu_sum;
  always_comb begin
    alu_sum = alu_a + alu_b;
    case ({sel2, sel1, sel0})
      3'b000:  alu_res = alu_a & alu_b;
      3'b001:  alu_res = alu_a | alu_b;
      3'b010:  alu_res = alu_a + alu_b;
      3'b011:  alu_res = alu_a ^ alu_b;
      3'b100:  alu_res = alu_a - alu_b;
      3'b101:  alu_res = alu_a >> alu_b[4:0];
      3'b110:  alu_res = alu_a << alu_b[4:0];
      default: alu_res = ~(alu_a | alu_b);
    endcase
  end
  assign alu_zero     = (alu_res == 32'd0);
  assign alu_overflow = (alu_a[31] == alu_b[31]) && (alu_sum[31] != alu_a[31]);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [2:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
    logic        trap;
    logic        ill;
    logic        wen;
    logic [4:0]  rd;
  } exp_t;

  logic [31:0] model_regs [32];
  exp_t        cur;
  int          age  = -1;   // cycles since acceptance; -1 = idle
  bit          live = 1'b0;
  int          cyc  = 0;

  function automatic exp_t predict(input logic [31:0] w);
    exp_t        e;
    logic [31:0] rs_v, rt_v;
    logic [4:0]  sh;
    longint      full;
    bit          ovf;
    e    = '0;
    ovf  = 1'b0;
    rs_v = model_regs[w[25:21]];
    rt_v = model_regs[w[20:16]];
    sh   = w[10:6];
    e.rd = w[15:11];
    e.a  = rs_v;
    e.b  = rt_v;
    if (w[31:26] != 6'd0) begin
      e.ill = 1'b1;
    end else begin
      case (w[5:0])
        6'h24: begin e.sel = 3'd0; e.res = rs_v & rt_v; end
        6'h25: begin e.sel = 3'd1; e.res = rs_v | rt_v; end
        6'h20, 6'h21: begin
          e.sel = 3'd2; e.res = rs_v + rt_v;
          full  = longint'($signed(rs_v)) + longint'($signed(rt_v));
          ovf   = (w[5:0] == 6'h20) && (full != longint'($signed(e.res)));
        end
        6'h26: begin e.sel = 3'd3; e.res = rs_v ^ rt_v; end
        6'h22, 6'h23: begin
          e.sel = 3'd4; e.res = rs_v - rt_v;
          full  = longint'($signed(rs_v)) - longint'($signed(rt_v));
          ovf   = (w[5:0] == 6'h22) && (full != longint'($signed(e.res)));
        end
        6'h02: begin e.sel = 3'd5; e.a = rt_v; e.b = {27'd0, sh}; e.res = rt_v >> sh; end
        6'h00: begin e.sel = 3'd6; e.a = rt_v; e.b = {27'd0, sh}; e.res = rt_v << sh; end
        6'h27: begin e.sel = 3'd7; e.res = ~(rs_v | rt_v); end
        default: e.ill = 1'b1;
      endcase
    end
    if (e.ill) begin
      e.a = 32'd0; e.b = 32'd0; e.sel = 3'd0; e.res = 32'd0;
    end
    e.zero = (e.res == 32'd0);
    e.trap = ovf;
    e.wen  = !e.ill && !ovf && (e.rd != 5'd0);
    return e;
  endfunction

  // DUT observations used by directed checks
  int          dut_acc_cyc  = -100;
  int          dut_done_cyc = -100;
  logic [31:0] dut_last_result;
  logic        dut_last_zero, dut_last_trap, dut_last_ill;
  logic [2:0]  dut_exec_sel;
  logic [31:0] dut_exec_b;

  // Compare process: check outputs for this cycle, then advance the model by
  // the inputs the coming rising edge will sample.
  always @(negedge clk) begin
    cyc++;
    if (live) begin
      check("ready", {31'd0, instr_ready}, {31'd0, (age < 0)});
      check("done",  {31'd0, done},        {31'd0, (age == 3)});
      if (age == 2) begin
        check("alu_sel", {29'd0, sel2, sel1, sel0}, {29'd0, cur.sel});
        check("alu_a", alu_a, cur.a);
        check("alu_b", alu_b, cur.b);
      end
      if (age == 3) begin
        check("illegal",  {31'd0, illegal},  {31'd0, cur.ill});
        check("ovf_trap", {31'd0, ovf_trap}, {31'd0, cur.trap});
        if (!cur.ill) begin
          check("result", result, cur.res);
          check("result_zero", {31'd0, result_zero}, {31'd0, cur.zero});
        end
      end
      check("dbg_data", dbg_data, model_regs[dbg_addr]);
    end
    if (instr_valid && instr_ready) dut_acc_cyc = cyc;
    if (cyc == dut_acc_cyc + 2) begin
      dut_exec_sel = {sel2, sel1, sel0};
      dut_exec_b   = alu_b;
    end
    if (done) begin
      dut_done_cyc    = cyc;
      dut_last_result = result;
      dut_last_zero   = result_zero;
      dut_last_trap   = ovf_trap;
      dut_last_ill    = illegal;
    end
    if (reset) begin
      live = 1'b1;
      age  = -1;
      for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
    end else if (live) begin
      if (age < 0) begin
        if (instr_valid) begin
          cur = predict(instr);
          age = 1;
        end
      end else if (age < 3) begin
        age = age + 1;
      end else begin
        if (cur.wen) model_regs[cur.rd] = cur.res;
        age = -1;
      end
    end
  end

  // ---------------- stimulus ----------------
  bit dbg_hold = 1'b0;

  // Random debug address every cycle unless a directed read owns the port.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!dbg_hold) dbg_addr = 5'($urandom);
    end
  end

  task automatic check_reg(input int a, input logic [31:0] v);
    @(posedge clk);
    #2;
    dbg_hold = 1'b1;
    dbg_addr = 5'(a);
    #1;
    check($sformatf("reg%0d", a), dbg_data, v);
    dbg_hold = 1'b0;
  endtask

  task automatic issue(input logic [31:0] w);
    bit ok;
    ok = 1'b0;
    instr       = w;
    instr_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (instr_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr       = $urandom;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("done_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [31:0] w);
    issue(w);
    wait_done();
  endtask

  logic [5:0] ftab [10] = '{6'h24, 6'h25, 6'h20, 6'h21, 6'h26,
                            6'h22, 6'h23, 6'h02, 6'h00, 6'h27};

  initial begin
    int          n_acc;
    int          k;
    logic [5:0]  op, fn;
    reset       = 1'b1;
    instr_valid = 1'b0;
    instr       = 32'd0;
    dbg_addr    = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", {31'd0, instr_ready}, 32'd1);
    check("rst_done",  {31'd0, done}, 32'd0);
    for (int i = 0; i < 32; i++) check_reg(i, 32'd0);

    // sub r1 = r0 - r0
    run(32'h0000_0822);
    check("sub0_result", dut_last_result, 32'd0);
    check("sub0_zero", {31'd0, dut_last_zero}, 32'd1);
    check("latency", 32'(dut_done_cyc - dut_acc_cyc), 32'd3);
    // nor r2 = r0 nor r0
    run(32'h0000_1027);
    check_reg(2, 32'hFFFF_FFFF);
    // srl r3 = r2 >> 31
    run(32'h0002_1FC2);
    check_reg(3, 32'd1);
    check("srl_sel", {29'd0, dut_exec_sel}, 32'd5);
    check("srl_b", dut_exec_b, 32'd31);
    // add r4 = r3 + r3
    run(32'h0063_2020);
    check_reg(4, 32'd2);
    // sll r5 = r2 << 31
    run(32'h0002_2FC0);
    check_reg(5, 32'h8000_0000);
    // add r6 = r5 + r5 overflows
    run(32'h00A5_3020);
    check("add_trap", {31'd0, dut_last_trap}, 32'd1);
    check_reg(6, 32'd0);
    // addu r6 = r5 + r5 wraps to zero
    run(32'h00A5_3021);
    check("addu_trap", {31'd0, dut_last_trap}, 32'd0);
    check("addu_zero", {31'd0, dut_last_zero}, 32'd1);
    check_reg(6, 32'd0);
    // sub r7 = r5 - r3 overflows with ALU flag low
    run(32'h00A3_3822);
    check("sub_trap", {31'd0, dut_last_trap}, 32'd1);
    check_reg(7, 32'd0);
    // illegal words
    run(32'h2001_0005);
    check("ill_op", {31'd0, dut_last_ill}, 32'd1);
    check_reg(1, 32'd0);
    run(32'h0022_482A);
    check("ill_funct", {31'd0, dut_last_ill}, 32'd1);
    check_reg(9, 32'd0);
    // add r0 = r3 + r3 must not stick
    run(32'h0063_0020);
    check_reg(0, 32'd0);

    // reset during EXEC of add r8 = r4 + r3
    issue(32'h0083_4020);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_ready", {31'd0, instr_ready}, 32'd1);
    check("abort_done", {31'd0, done}, 32'd0);
    check_reg(8, 32'd0);
    check_reg(4, 32'd0);

    // continuous valid: one acceptance every 4 cycles
    @(posedge clk);
    #1;
    instr       = 32'h0000_1027;
    instr_valid = 1'b1;
    n_acc       = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (instr_ready) n_acc++;
    end
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    check("throughput", 32'(n_acc), 32'd5);
    repeat (4) @(posedge clk);
    #1;

    // randomized instructions
    for (int n = 0; n < 150; n++) begin
      k  = $urandom_range(0, 11);
      op = 6'd0;
      if (k < 10) fn = ftab[k];
      else if (k == 10) fn = 6'h2A;
      else begin
        fn = 6'($urandom);
        op = 6'($urandom_range(1, 63));
      end
      issue({op, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), fn});
      repeat ($urandom_range(0, 4)) begin
        @(posedge clk);
        #1;
      end
    end
    repeat (8) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rtype_exec_seq.md
Name: rtype_exec_seq

Overview:
- Multi-cycle R-type execution sequencer: the initiator side of the 32-bit ALU interface.
- Accepts one MIPS R-type instruction per valid/ready handshake and reads operands from its internal 32x32 register file.
- Drives the ALU's three select bits and operands, captures result/zero/overflow, and writes back to rd.
- Sits between instruction delivery and the external ALU instance in the single-issue R-type datapath.

Parameters:
TRAP_ON_OVF, 1, 1: signed overflow on add/sub suppresses writeback and flags ovf_trap; 0: always write back.

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
instr_valid  in  1  instruction offered
instr_ready  out  1  sequencer can accept (high only in IDLE)
instr  in  32  R-type word: op[31:26] rs[25:21] rt[20:16] rd[15:11] shamt[10:6] funct[5:0]
ALUselector2  out  1  ALU select bit 2
ALUselector1  out  1  ALU select bit 1
ALUselector0  out  1  ALU select bit 0
alu_a  out  32  ALU operand a
alu_b  out  32  ALU operand b
alu_res  in  32  ALU result
alu_zero  in  1  ALU zero flag
alu_overflow  in  1  ALU add-form overflow flag
done  out  1  one-cycle completion pulse
result  out  32  captured ALU result, valid while done=1
result_zero  out  1  captured zero flag, valid while done=1
ovf_trap  out  1  overflow trap, valid while done=1
illegal  out  1  unsupported instruction, valid while done=1
dbg_addr  in  5  debug register read address
dbg_data  out  32  combinational read of reg[dbg_addr]; reg 0 reads 0

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset: state=IDLE. All outputs 0 except instr_ready=1. All 32 registers cleared to 0.
- Reset mid-operation: the in-flight instruction is abandoned with no writeback and no done pulse.
- FSM: IDLE -> READ -> EXEC -> WB -> IDLE.
  - IDLE: instr_ready=1. On instr_valid=1, latch instr and go to READ. No other state accepts.
  - READ: decode; latch op_a/op_b and the select bits into output registers.
  - EXEC: ALU inputs are stable; sample alu_res, alu_zero and alu_overflow at the end of the cycle.
  - WB: done=1 for exactly one cycle together with result, result_zero, ovf_trap and illegal. The register write takes effect at the end of the WB cycle.
- Latency: handshake in cycle N -> done in cycle N+3. Back-to-back throughput is one instruction per 4 cycles.
- Decode, funct -> {ALUselector2,1,0}, a, b:
  - 0x24 and -> 000, rs, rt
  - 0x25 or -> 001, rs, rt
  - 0x20 add / 0x21 addu -> 010, rs, rt
  - 0x26 xor -> 011, rs, rt
  - 0x22 sub / 0x23 subu -> 100, rs, rt
  - 0x02 srl -> 101, a=rt, b=zero-extended shamt
  - 0x00 sll -> 110, a=rt, b=zero-extended shamt
  - 0x27 nor -> 111, rs, rt
- Illegal: op!=0 or any other funct sets illegal=1 in WB, with no writeback and selects/operands driven 0. Sequencing is unchanged: still 4 cycles.
- Overflow:
  - add: ovf = alu_overflow.
  - sub: the block computes ovf itself as (a[31]!=b[31]) and (res[31]!=a[31]); alu_overflow is ignored because it is add-form only.
  - addu, subu and logic/shift ops: ovf=0.
  - With TRAP_ON_OVF=1 and ovf=1: ovf_trap=1, no write.
- Writeback: reg[rd] <= result unless rd=0, illegal, or trap. Register 0 always reads 0.
- Read-after-write: an instruction accepted the cycle after a WB sees the updated value, since READ follows the write edge.
- Outside READ/EXEC, ALU outputs hold their last values. Downstream must not sample them outside EXEC.
- Debug port is a read-only side channel and never stalls the FSM.

Test Plan:
- Reset, then dbg reads of all 32 regs -> all 0; instr_ready=1, done=0.
- Preload via chained ops: sub r1=r0-r0 (0x00000822) -> result 0, result_zero=1, done at N+3. Then nor r2=r0 nor r0 (0x00001027) -> r2=0xFFFFFFFF. Then srl r3=r2>>31 (0x00021FC2) -> r3=1, selects 101, alu_b=31.
- add r4=r3+r3 -> 2. sll r5,r2,31 (0x00022FC0) -> 0x80000000. add r6=r5+r5 -> alu_overflow=1, ovf_trap=1, r6 stays 0. addu r6=r5+r5 -> r6=0, result_zero=1, no trap.
- Sub overflow: sub r7=r5-r3 (0x80000000-1) -> ovf_trap=1, r7 unchanged, even though alu_overflow=0.
- illegal: instr=0x20010005 (op!=0) and funct 0x2A -> illegal=1 at N+3, no register changes. Write to rd=0 -> dbg r0=0.
- Reset asserted in EXEC of add r8 -> no done, r8=0, instr_ready=1 next cycle. Hold instr_valid high continuously -> accepts exactly every 4th cycle.
